// File: rtl/mul_sched.sv
// mul_sched: two requesters share one unsigned 8x8 Dadda multiplier for signed 8x8->16 products (`MUL_SCHED_RR_EN selects round-robin, else req0 priority).
// Latency: res_valid 3 cycles after operand acceptance; one transaction in flight, next accept the cycle after the result handshake.
// Backpressure: result held in DONE until res_ready; both req readys stay low whenever the scheduler is not IDLE.

module dada_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  // Column-wise Dadda reduction (heights 6,4,3,2) followed by one carry-propagate add.
  always_comb begin
    logic [15:0] cur [16];
    logic [15:0] nxt [16];
    int          hc [16];
    int          hn [16];
    logic [15:0] row0;
    logic [15:0] row1;
    int          idx;
    int          rem;
    int          d;
    logic        s;
    logic        c;
    logic        x;
    logic        y;
    logic        z;
    row0 = '0;
    row1 = '0;
    idx  = 0;
    rem  = 0;
    d    = 0;
    s    = 1'b0;
    c    = 1'b0;
    x    = 1'b0;
    y    = 1'b0;
    z    = 1'b0;
    for (int j = 0; j < 16; j++) begin
      cur[j] = '0;
      nxt[j] = '0;
      hc[j]  = 0;
      hn[j]  = 0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 8; k++) begin
        cur[i+k][4'(hc[i+k])] = a[i] & b[k];
        hc[i+k] = hc[i+k] + 1;
      end
    end
    for (int st = 0; st < 4; st++) begin
      d = (st == 0) ? 6 : (st == 1) ? 4 : (st == 2) ? 3 : 2;
      for (int j = 0; j < 16; j++) begin
        nxt[j] = '0;
        hn[j]  = 0;
      end
      for (int j = 0; j < 16; j++) begin
        idx = 0;
        for (int t = 0; t < 8; t++) begin
          rem = hc[j] - idx + hn[j];
          if (rem > d) begin
            x = cur[j][4'(idx)];
            y = cur[j][4'(idx + 1)];
            if (rem == d + 1) begin
              s   = x ^ y;
              c   = x & y;
              idx = idx + 2;
            end else begin
              z   = cur[j][4'(idx + 2)];
              s   = x ^ y ^ z;
              c   = (x & y) | (x & z) | (y & z);
              idx = idx + 3;
            end
            nxt[j][4'(hn[j])] = s;
            hn[j] = hn[j] + 1;
            if (j < 15) begin
              nxt[4'(j + 1)][4'(hn[4'(j + 1)])] = c;
              hn[4'(j + 1)] = hn[4'(j + 1)] + 1;
            end
          end
        end
        for (int k = 0; k < 16; k++) begin
          if (k >= idx && k < hc[j]) begin
            nxt[j][4'(hn[j])] = cur[j][k];
            hn[j] = hn[j] + 1;
          end
        end
      end
      for (int j = 0; j < 16; j++) begin
        cur[j] = nxt[j];
        hc[j]  = hn[j];
      end
    end
    for (int j = 0; j < 16; j++) begin
      row0[j] = cur[j][0];
      row1[j] = cur[j][1];
    end
    p = row0 + row1;
  end
endmodule

module mul_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_id,
  input  logic        res_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CONV, MUL, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  mag_a_q;
  logic [7:0]  mag_b_q;
  logic        sign_q;
  logic        id_q;
  logic        grant_id;
  logic        accept;
  logic [15:0] prod;

`ifdef MUL_SCHED_RR_EN
  // Last granted requester; resets to 1 so requester 0 wins the first tie.
  logic last_q;

  always_comb begin
    grant_id = !req0_valid;
    if (req0_valid && req1_valid) grant_id = !last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= grant_id;
  end
`else
  assign grant_id = !req0_valid;
`endif

  assign accept     = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign busy       = rst_n && (state_q != IDLE);
  assign res_valid  = rst_n && (state_q == DONE);

  dada_mul u_mul (
    .a (mag_a_q),
    .b (mag_b_q),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    state_d = MUL;
      MUL:     state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sign_q   <= 1'b0;
      res_data <= '0;
      res_id   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q  <= grant_id ? req1_a : req0_a;
          b_q  <= grant_id ? req1_b : req0_b;
          id_q <= grant_id;
        end
        // 0x80 negates to itself, which reads correctly as unsigned 128.
        CONV: begin
          mag_a_q <= a_q[7] ? (~a_q + 8'd1) : a_q;
          mag_b_q <= b_q[7] ? (~b_q + 8'd1) : b_q;
          sign_q  <= a_q[7] ^ b_q[7];
        end
        MUL: begin
          res_data <= sign_q ? (~prod + 16'd1) : prod;
          res_id   <= id_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed vector table, multi-cycle corner sequences and a randomized run against a timing/arithmetic model.
module tb_mul_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_id;
  logic        res_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  typedef struct {
    bit          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       tag;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed({{8{a[7]}}, a});
    sb = $signed({{8{b[7]}}, b});
    return 16'(sa * sb);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Single transaction from an idle scheduler with res_ready high.
  task automatic do_txn(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
    int lat;
    idle_inputs();
    res_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    check({tag, "_ready"}, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 8'($urandom); req0_b = 8'($urandom);
    req1_a = 8'($urandom); req1_b = 8'($urandom);
    lat = 1;
    while (!res_valid && lat < 10) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, res_data, exp);
    check({tag, "_id"}, res_id, id);
    step();
    check({tag, "_valid_drop"}, res_valid, 1'b0);
    check({tag, "_data_kept"}, res_data, exp);
  endtask

  task automatic rand_test(input int cycles);
    bit          pend;
    bit          last;
    bit          g;
    bit          any;
    int          acc;
    logic [15:0] md;
    bit          mid;
    pend = 1'b0;
    last = 1'b1;
    acc  = 0;
    md   = '0;
    mid  = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!pend) begin
        any = req0_valid || req1_valid;
`ifdef MUL_SCHED_RR_EN
        g = (req0_valid && req1_valid) ? !last : !req0_valid;
`else
        g = !req0_valid;
`endif
        check("rand_ready", {req1_ready, req0_ready}, {any && g, any && !g});
        check("rand_idle_valid", res_valid, 1'b0);
        if (any) begin
          pend = 1'b1;
          acc  = cyc;
          mid  = g;
          md   = g ? ref_prod(req1_a, req1_b) : ref_prod(req0_a, req0_b);
          last = g;
        end
      end else begin
        check("rand_busy_ready", {req1_ready, req0_ready}, 2'b00);
        check("rand_valid", res_valid, (cyc - acc) >= 3);
        if ((cyc - acc) >= 3) begin
          check("rand_data", res_data, md);
          check("rand_id", res_id, mid);
          if (res_ready) pend = 1'b0;
        end
      end
      step();
    end
    idle_inputs();
    res_ready = 1'b1;
  endtask

  initial begin
    int          got;
    bit          seen;
    bit          ids [4];
    logic [15:0] ds [4];

    tbl[0] = '{0, 8'h05, 8'hFD, 16'hFFF1, "v_5xm3"};
    tbl[1] = '{1, 8'h80, 8'h80, 16'h4000, "v_m128sq"};
    tbl[2] = '{1, 8'h80, 8'h7F, 16'hC080, "v_m128x127"};
    tbl[3] = '{0, 8'h00, 8'h80, 16'h0000, "v_zero_neg"};
    tbl[4] = '{1, 8'h7F, 8'h7F, 16'h3F01, "v_127sq"};
    tbl[5] = '{0, 8'hFF, 8'h01, 16'hFFFF, "v_m1x1"};
    tbl[6] = '{1, 8'hFF, 8'hFF, 16'h0001, "v_m1sq"};
    tbl[7] = '{0, 8'h81, 8'h7F, 16'hC0FF, "v_m127x127"};
    tbl[8] = '{1, 8'h80, 8'h01, 16'hFF80, "v_m128x1"};

    // Reset behaviour, including combinational gating while rst_n is low.
    idle_inputs();
    res_ready  = 1'b1;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    check("rst_ready_low", {req1_ready, req0_ready}, 2'b00);
    check("rst_busy_low", busy, 1'b0);
    step();
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_res_id", res_id, 1'b0);
    idle_inputs();
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", busy, 1'b0);

    for (int i = 0; i < 9; i++)
      do_txn(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].tag);

    // Result held under backpressure; requests ignored while busy.
    idle_inputs();
    res_ready  = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'hF9;
    step();
    req1_valid = 1'b0;
    got = 0;
    while (!res_valid && got < 10) begin step(); got++; end
    check("stall_reached_done", res_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      #1;
      check("stall_valid", res_valid, 1'b1);
      check("stall_data", res_data, 16'hFFEB);
      check("stall_id", res_id, 1'b1);
      check("stall_readys", {req1_ready, req0_ready}, 2'b00);
      check("stall_busy", busy, 1'b1);
      step();
    end
    idle_inputs();
    res_ready = 1'b1;
    #1;
    check("stall_valid_last", res_valid, 1'b1);
    step();
    check("stall_release", res_valid, 1'b0);
    check("stall_data_kept", res_data, 16'hFFEB);
    check("stall_id_kept", res_id, 1'b1);

    // Reset while in MUL aborts the transaction.
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    #1;
    check("abort_accept", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    step();
    check("abort_in_mul_busy", busy, 1'b1);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("abort_rst_busy", busy, 1'b0);
    check("abort_rst_ready", {req1_ready, req0_ready}, 2'b00);
    step();
    rst_n = 1'b1;
    req0_valid = 1'b0;
    check("abort_data", res_data, 16'h0000);
    check("abort_id", res_id, 1'b0);
    seen = res_valid;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | res_valid;
    end
    check("abort_no_valid", seen, 1'b0);
    do_txn(0, 8'h07, 8'h00, 16'h0000, "abort_next");

    // Both requesters held valid: arbitration order.
    do_reset();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h03;
    req1_valid = 1'b1; req1_a = 8'hFC; req1_b = 8'hFB;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      step();
      if (res_valid) begin
        ids[got] = res_id;
        ds[got]  = res_data;
        got++;
      end
    end
    idle_inputs();
    check("arb_count", got, 4);
    for (int i = 0; i < got; i++) begin
`ifdef MUL_SCHED_RR_EN
      check("arb_id", ids[i], i % 2);
`else
      check("arb_id", ids[i], 1'b0);
`endif
      check("arb_data", ds[i], ids[i] ? 16'h0014 : 16'h0006);
    end
    step();

    do_reset();
    rand_test(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester 0/1 operand pair valid.
REQ-004 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 8 bits each: signed two's-complement operands.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operand pair is accepted in any cycle where valid and ready are both high.
REQ-006 SHALL have port res_valid, output, 1 bit: result available.
REQ-007 SHALL have port res_data, output, 16 bits: signed product.
REQ-008 SHALL have port res_id, output, 1 bit: index of the requester that owns res_data.
REQ-009 SHALL have port res_ready, input, 1 bit: consumer accepts the result in any cycle where res_valid and res_ready are both high.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL share one instance of the team's unsigned 8x8 Dadda multiplier (dada_mul) between both requesters.
REQ-012 SHALL implement FSM states IDLE, CONV, MUL and DONE, with exactly one transaction in flight.
REQ-013 In IDLE with at least one valid, SHALL grant one requester, capture its a/b and the id, and go to CONV.
REQ-014 In IDLE with no valid, SHALL remain in IDLE.
REQ-015 reqN_ready SHALL be combinational: high only when state==IDLE and requester N is the current-cycle grant; the other ready is low.
REQ-016 In CONV, SHALL register the magnitude of each operand (two's-complement negation when bit 7 is set) and the sign a[7]^b[7], then go to MUL.
REQ-017 Magnitude of -128 (0x80) SHALL be 0x80, treated as unsigned 128.
REQ-018 In MUL, SHALL register into res_data the dada_mul product of the two magnitudes, negated (16-bit two's complement) if sign=1, then go to DONE.
REQ-019 Worked ranges: (-128)x(-128)=0x4000; (-128)x127=0xC080; a zero product SHALL yield 0x0000 regardless of sign.
REQ-020 In DONE, res_valid SHALL be 1; res_data and res_id SHALL be held stable until res_ready.
REQ-021 In DONE with res_ready=1, SHALL return to IDLE; res_valid SHALL be 0 from the next cycle.
REQ-022 Latency: operands accepted in cycle N SHALL give res_valid=1 in cycle N+3.
REQ-023 The earliest next acceptance SHALL be the cycle after the result handshake; steady-state throughput SHALL be one product per 4 cycles.
REQ-024 Operand changes on any request port while not IDLE SHALL have no effect; no new request is accepted until IDLE.
REQ-025 res_data and res_id SHALL keep their last values after leaving DONE, until the next MUL state.

Reset
REQ-026 On rst_n=0 at a clock edge, SHALL set state=IDLE, res_valid=0, res_data=0x0000, res_id=0, and clear the internal operand, magnitude and sign registers.
REQ-027 On reset, the round-robin pointer SHALL favour requester 0.
REQ-028 Reset in CONV, MUL or DONE SHALL abort the transaction; no res_valid for it SHALL ever appear.
REQ-029 While rst_n=0, req0_ready, req1_ready and busy SHALL be 0.

Configuration
REQ-030 With macro MUL_SCHED_RR_EN defined, arbitration SHALL be round-robin: on simultaneous valids, the requester not granted last SHALL win; the pointer updates only on acceptance.
REQ-031 Without MUL_SCHED_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning ties; the pointer logic is absent.

Verification
REQ-032 Scenario: req0 a=0x05, b=0xFD (-3), res_ready=1 -> res_valid 3 cycles after acceptance, res_data=0xFFF1, res_id=0.
REQ-033 Scenario: req1 a=0x80, b=0x80 -> res_data=0x4000, res_id=1; then a=0x80, b=0x7F -> res_data=0xC080.
REQ-034 Scenario: both valid continuously with a=2, b=3 and a=-4, b=-5 -> RR_EN gives res_id sequence 0,1,0,1 with data 0x0006, 0x0014; without the macro the sequence is 0,0,0,0.
REQ-035 Scenario: res_ready held low 5 cycles in DONE -> res_valid, res_data and res_id stable for those cycles; both readys low; busy=1.
REQ-036 Scenario: rst_n=0 for one cycle while in MUL with a=-1, b=-1 -> no res_valid follows; outputs are 0; next request a=7, b=0 -> res_data=0x0000.
